// File: rtl/result_slot_allocator_pkg.sv
// Package ethsniff_result_pkg: types and constants shared by the result-slot
// allocator and its round-robin arbiter.
//   alloc_state_t       : allocator FSM states (IDLE, ISSUE)
//   SLOT_STRIDE_DEFAULT : bytes per result slot (one max Ethernet frame, 1550 B)
//   MAX_FRAME_BYTES     : largest frame a slot must hold
//   idx_width()         : width of an index into n items, never below 1 bit
package ethsniff_result_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    ISSUE = 1'b1
  } alloc_state_t;

  localparam logic [31:0] SLOT_STRIDE_DEFAULT = 32'h0000_060E;
  localparam int          MAX_FRAME_BYTES     = 1550;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: round-robin arbiter over N level requests.
//   clk, n_rst : clock (rising edge) and asynchronous active-low reset
//   clear      : synchronous return of the priority pointer to channel 0
//   req[N]     : request vector
//   advance    : the current winner was taken; move priority past it
//   grant[N]   : one-hot winner (all zero when no request)
//   idx        : index of the winner (0 when no request)
// The search starts at ptr_reg, which always names the channel after the one
// granted last. N = 1 collapses to a direct grant of the single request.
module rr_arbiter
  import ethsniff_result_pkg::*;
#(
  parameter  int N  = 2,
  localparam int IW = idx_width(N)
) (
  input  logic          clk,
  input  logic          n_rst,
  input  logic          clear,
  input  logic [N-1:0]  req,
  input  logic          advance,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] idx
);

  logic [IW-1:0] ptr_reg;
  logic [IW-1:0] ptr_next;
  logic [N-1:0]  upper_mask;
  logic [N-1:0]  req_upper;
  logic [N-1:0]  sel;

  // Channels at or above the pointer get first pick; if none of them is
  // requesting, the search wraps around to the lowest requesting channel.
  genvar gi;
  generate
    for (gi = 0; gi < N; gi++) begin : g_mask
      assign upper_mask[gi] = (IW'(gi) >= ptr_reg);
    end
  endgenerate

  assign req_upper = req & upper_mask;

  always_comb begin
    sel   = (|req_upper) ? req_upper : req;
    idx   = '0;
    grant = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if (sel[i]) idx = IW'(i);
    end
    grant = N'(|req) << idx;
  end

  always_comb begin
    ptr_next = ptr_reg;
    if (clear) begin
      ptr_next = '0;
    end else if (advance && |req) begin
      ptr_next = (idx == IW'(N - 1)) ? '0 : idx + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) ptr_reg <= '0;
    else        ptr_reg <= ptr_next;
  end

endmodule

// File: rtl/result_slot_allocator.sv
// result_slot_allocator: hands out fixed-size result slots of a circular
// buffer to NUM_CH requesters (round-robin) and tracks how many are filled.
//   clk, n_rst   : clock (rising edge) and asynchronous active-low reset
//   clear        : synchronous flush of pointer, count, error and any write
//   inc_addr     : per-channel level request for a new slot
//   grant        : one-hot, single-cycle acceptance pulse
//   ch_id        : channel owning the current/last write
//   addr_out     : base address of the slot being/last written
//   write_enable : write strobe, held until wr_ready
//   wr_ready     : memory side accepts the write this cycle
//   slot_release : reader frees the oldest filled slot
//   count        : number of filled slots
//   full, empty  : count == NUM_SLOTS / count == 0
//   release_err  : sticky, a release arrived with nothing to free
// A grant in cycle N loads addr_out/ch_id and raises write_enable at N+1, so
// each allocation takes at least two cycles.
module result_slot_allocator
  import ethsniff_result_pkg::*;
#(
  parameter  int          ADDR_W    = 32,
  parameter  logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter  logic [31:0] STRIDE    = SLOT_STRIDE_DEFAULT,
  parameter  int          NUM_SLOTS = 16,
  parameter  int          NUM_CH    = 2,
  localparam int          CH_W      = idx_width(NUM_CH),
  localparam int          CNT_W     = $clog2(NUM_SLOTS + 1)
) (
  input  logic              clk,
  input  logic              n_rst,
  input  logic              clear,
  input  logic [NUM_CH-1:0] inc_addr,
  output logic [NUM_CH-1:0] grant,
  output logic [CH_W-1:0]   ch_id,
  output logic [ADDR_W-1:0] addr_out,
  output logic              write_enable,
  input  logic              wr_ready,
  input  logic              slot_release,
  output logic [CNT_W-1:0]  count,
  output logic              full,
  output logic              empty,
  output logic              release_err
);

  localparam int                SLOT_W   = $clog2(NUM_SLOTS);
  localparam logic [ADDR_W-1:0] BASE_A   = ADDR_W'(BASE_ADDR);
  localparam logic [ADDR_W-1:0] STRIDE_A = ADDR_W'(STRIDE);

  alloc_state_t      state_reg, state_next;
  logic [SLOT_W-1:0] slot_idx_reg, slot_idx_next;
  logic [ADDR_W-1:0] addr_reg, addr_next;
  logic [CH_W-1:0]   ch_id_reg, ch_id_next;
  logic [CNT_W-1:0]  count_reg, count_next;
  logic              release_err_reg, release_err_next;

  logic [NUM_CH-1:0] arb_grant;
  logic [CH_W-1:0]   arb_idx;
  logic [CNT_W:0]    occupancy;
  logic              admit;
  logic              do_grant;
  logic              complete;
  logic              slot_wrap;

  // Occupancy includes the write still in flight, so a new slot is never
  // handed out on top of one the reader has not released yet.
  assign occupancy = {1'b0, count_reg} + {{CNT_W{1'b0}}, (state_reg == ISSUE)};
  assign admit     = (occupancy < (CNT_W + 1)'(NUM_SLOTS));
  assign do_grant  = (state_reg == IDLE) && !clear && (|inc_addr) && admit;
  assign complete  = (state_reg == ISSUE) && wr_ready;
  assign slot_wrap = (slot_idx_reg == SLOT_W'(NUM_SLOTS - 1));

  rr_arbiter #(
    .N (NUM_CH)
  ) u_arb (
    .clk     (clk),
    .n_rst   (n_rst),
    .clear   (clear),
    .req     (inc_addr),
    .advance (do_grant),
    .grant   (arb_grant),
    .idx     (arb_idx)
  );

  always_comb begin
    state_next       = state_reg;
    slot_idx_next    = slot_idx_reg;
    addr_next        = addr_reg;
    ch_id_next       = ch_id_reg;
    count_next       = count_reg;
    release_err_next = release_err_reg;

    if (clear) begin
      state_next       = IDLE;
      slot_idx_next    = '0;
      addr_next        = BASE_A;
      ch_id_next       = '0;
      count_next       = '0;
      release_err_next = 1'b0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (do_grant) begin
            state_next = ISSUE;
            ch_id_next = arb_idx;
            // Index advances before use; the running sum avoids a multiplier
            // and reloads the base when the ring wraps back to slot 0.
            if (slot_wrap) begin
              slot_idx_next = '0;
              addr_next     = BASE_A;
            end else begin
              slot_idx_next = slot_idx_reg + 1'b1;
              addr_next     = addr_reg + STRIDE_A;
            end
          end
        end
        ISSUE: begin
          if (wr_ready) state_next = IDLE;
        end
        default: state_next = IDLE;
      endcase

      // A completion and a release in the same cycle cancel out.
      if (complete && !slot_release) begin
        count_next = count_reg + 1'b1;
      end else if (slot_release && !complete) begin
        if (count_reg != '0) count_next = count_reg - 1'b1;
        else                 release_err_next = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_reg       <= IDLE;
      slot_idx_reg    <= '0;
      addr_reg        <= BASE_A;
      ch_id_reg       <= '0;
      count_reg       <= '0;
      release_err_reg <= 1'b0;
    end else begin
      state_reg       <= state_next;
      slot_idx_reg    <= slot_idx_next;
      addr_reg        <= addr_next;
      ch_id_reg       <= ch_id_next;
      count_reg       <= count_next;
      release_err_reg <= release_err_next;
    end
  end

  assign grant        = do_grant ? arb_grant : '0;
  assign ch_id        = ch_id_reg;
  assign addr_out     = addr_reg;
  assign write_enable = (state_reg == ISSUE);
  assign count        = count_reg;
  assign full         = (count_reg == CNT_W'(NUM_SLOTS));
  assign empty        = (count_reg == '0);
  assign release_err  = release_err_reg;

endmodule

// File: tb/tb_result_slot_allocator.sv
// Testbench for result_slot_allocator: directed scenarios followed by random
// traffic, every cycle compared against a transaction-level reference model.
module tb_result_slot_allocator;

  localparam int          AW     = 32;
  localparam int          NS     = 4;
  localparam int          NCH    = 2;
  localparam logic [31:0] BASE   = 32'h0000_1000;
  localparam logic [31:0] STRIDE = 32'h0000_060E;
  localparam int          CW     = $clog2(NS + 1);

  logic           clk = 1'b0;
  logic           n_rst = 1'b0;
  logic           clear = 1'b0;
  logic           wr_ready = 1'b0;
  logic           slot_release = 1'b0;
  logic [NCH-1:0] inc_addr = '0;

  logic [NCH-1:0] grant;
  logic [0:0]     ch_id;
  logic [AW-1:0]  addr_out;
  logic           write_enable;
  logic [CW-1:0]  count;
  logic           full;
  logic           empty;
  logic           release_err;

  always #5 clk = ~clk;

  result_slot_allocator #(
    .ADDR_W    (AW),
    .BASE_ADDR (BASE),
    .STRIDE    (STRIDE),
    .NUM_SLOTS (NS),
    .NUM_CH    (NCH)
  ) dut (
    .clk          (clk),
    .n_rst        (n_rst),
    .clear        (clear),
    .inc_addr     (inc_addr),
    .grant        (grant),
    .ch_id        (ch_id),
    .addr_out     (addr_out),
    .write_enable (write_enable),
    .wr_ready     (wr_ready),
    .slot_release (slot_release),
    .count        (count),
    .full         (full),
    .empty        (empty),
    .release_err  (release_err)
  );

  int tests_run    = 0;
  int tests_failed = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s at t=%0t: got 0x%0h, expected 0x%0h", tag, $time, got, exp);
    end
  endtask

  // Reference model: a write in flight or not, number of allocations since
  // reset/clear, the owner and address of the last one, the channel with
  // first priority, and the number of filled slots.
  bit            m_busy;
  int            m_allocs;
  int            m_ch;
  int            m_ptr;
  int            m_count;
  bit            m_err;
  logic [AW-1:0] m_addr;

  function automatic logic [AW-1:0] slot_addr(input int n);
    longint a;
    a = longint'(BASE) + longint'(n % NS) * longint'(STRIDE);
    return AW'(a);
  endfunction

  task automatic model_reset();
    m_busy   = 1'b0;
    m_allocs = 0;
    m_ch     = 0;
    m_ptr    = 0;
    m_count  = 0;
    m_err    = 1'b0;
    m_addr   = slot_addr(0);
  endtask

  // One clock cycle: apply inputs (just after posedge), check at negedge,
  // then advance the model to the next cycle.
  task automatic step(input logic [NCH-1:0] inc, input logic wrr,
                      input logic rel, input logic clr);
    int             win;
    int             c;
    bit             done;
    logic [NCH-1:0] exp_grant;
    inc_addr     = inc;
    wr_ready     = wrr;
    slot_release = rel;
    clear        = clr;
    @(negedge clk);

    win = -1;
    if (!clr && !m_busy && m_count < NS) begin
      for (int k = 0; k < NCH; k++) begin
        c = (m_ptr + k) % NCH;
        if (win < 0 && inc[c]) win = c;
      end
    end
    exp_grant = '0;
    if (win >= 0) exp_grant[win] = 1'b1;

    check_eq("grant",        64'(grant),        64'(exp_grant));
    check_eq("write_enable", 64'(write_enable), 64'(m_busy));
    check_eq("addr_out",     64'(addr_out),     64'(m_addr));
    check_eq("ch_id",        64'(ch_id),        64'(m_ch));
    check_eq("count",        64'(count),        64'(m_count));
    check_eq("full",         64'(full),         64'(m_count == NS));
    check_eq("empty",        64'(empty),        64'(m_count == 0));
    check_eq("release_err",  64'(release_err),  64'(m_err));

    if (win >= 0)
      $display("[TB] t=%0t grant ch%0d slot_addr=0x%08h count=%0d",
               $time, win, slot_addr(m_allocs + 1), m_count);

    if (clr) begin
      model_reset();
    end else begin
      done = m_busy && wrr;
      if (win >= 0) begin
        m_allocs++;
        m_addr = slot_addr(m_allocs);
        m_ch   = win;
        m_ptr  = (win + 1) % NCH;
        m_busy = 1'b1;
      end
      if (done) m_busy = 1'b0;
      if (done && !rel) begin
        m_count++;
      end else if (rel && !done) begin
        if (m_count > 0) m_count--;
        else             m_err = 1'b1;
      end
    end
    @(posedge clk);
    #1;
  endtask

  logic [NCH-1:0] r_inc;
  logic           r_wrr, r_rel, r_clr;

  initial begin
    // Reset values while n_rst is held low.
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_write_enable", 64'(write_enable), 64'(0));
    check_eq("rst_addr_out",     64'(addr_out),     64'(BASE));
    check_eq("rst_count",        64'(count),        64'(0));
    check_eq("rst_empty",        64'(empty),        64'(1));
    check_eq("rst_release_err",  64'(release_err),  64'(0));
    check_eq("rst_grant",        64'(grant),        64'(0));
    n_rst = 1'b1;
    model_reset();

    // Idle after reset.
    repeat (3) step('0, 1'b0, 1'b0, 1'b0);

    // Single pulses on channel 0 with memory always ready; fills the ring.
    repeat (4) begin
      step(2'b01, 1'b1, 1'b0, 1'b0);
      step(2'b00, 1'b1, 1'b0, 1'b0);
    end

    // Full: requests wait, one release lets the next grant (wrapped slot) go.
    repeat (3) step(2'b01, 1'b1, 1'b0, 1'b0);
    step(2'b01, 1'b1, 1'b1, 1'b0);
    repeat (3) step(2'b01, 1'b1, 1'b0, 1'b0);

    // Drain, then both channels held: alternating grants.
    repeat (5) step(2'b00, 1'b1, 1'b1, 1'b0);
    repeat (8) step(2'b11, 1'b1, 1'b0, 1'b0);
    repeat (4) step(2'b00, 1'b1, 1'b1, 1'b0);

    // Memory stall during ISSUE, then completion, then completion + release.
    step(2'b10, 1'b0, 1'b0, 1'b0);
    repeat (5) step(2'b11, 1'b0, 1'b0, 1'b0);
    step(2'b00, 1'b1, 1'b0, 1'b0);
    step(2'b01, 1'b1, 1'b0, 1'b0);
    step(2'b00, 1'b1, 1'b1, 1'b0);

    // Release while empty, then clear in the middle of a write.
    repeat (3) step(2'b00, 1'b0, 1'b1, 1'b0);
    step(2'b01, 1'b0, 1'b0, 1'b0);
    step(2'b00, 1'b0, 1'b0, 1'b1);
    repeat (2) step(2'b00, 1'b0, 1'b0, 1'b0);

    // Asynchronous reset in the middle of a write.
    step(2'b01, 1'b0, 1'b0, 1'b0);
    inc_addr = '0;
    #2;
    check_eq("we_before_async_rst", 64'(write_enable), 64'(m_busy));
    n_rst = 1'b0;
    #1;
    check_eq("async_rst_write_enable", 64'(write_enable), 64'(0));
    check_eq("async_rst_addr_out",     64'(addr_out),     64'(BASE));
    check_eq("async_rst_count",        64'(count),        64'(0));
    model_reset();
    @(posedge clk);
    #1;
    n_rst = 1'b1;
    repeat (2) step('0, 1'b0, 1'b0, 1'b0);

    // Random traffic.
    for (int cyc = 0; cyc < 1500; cyc++) begin
      r_inc = NCH'($urandom_range(0, (1 << NCH) - 1));
      r_wrr = ($urandom_range(0, 3) != 0);
      r_rel = ($urandom_range(0, 2) == 0);
      r_clr = ($urandom_range(0, 79) == 0);
      step(r_inc, r_wrr, r_rel, r_clr);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
